// File: rtl/axi_dma_reader.sv
// AXI3 read-burst master: one INCR burst of 1..16 32-bit words per start,
// each returned word presented on a registered data/valid pair throttled by ready.
module axi_dma_reader #(
    parameter logic [5:0] ARID = 6'd0
) (
    input  logic        clk,
    input  logic        reset,
    // AXI read address channel
    output logic [5:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic [1:0]  m_arlock,
    output logic [3:0]  m_arcache,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    // AXI read data channel
    input  logic [5:0]  m_rid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    // AXI write channels, tied off
    output logic [5:0]  m_awid,
    output logic [31:0] m_awaddr,
    output logic [3:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic [1:0]  m_awlock,
    output logic [3:0]  m_awcache,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [5:0]  m_wid,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [5:0]  m_bid,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    // consumer side
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [3:0]  burstlen,
    input  logic        ready,
    output logic        busy,
    output logic [31:0] data,
    output logic        valid,
    output logic        done,
    output logic        error
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RADDR = 2'd1;
    localparam logic [1:0] RDATA = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        busy_q, busy_d;
    logic        arvalid_q, arvalid_d;
    logic        beat_s;
    logic        unused_s;

    // rready is the single combinational output, gated by registered state
    assign m_rready  = (state_q == RDATA) & ready;
    assign beat_s    = m_rvalid & m_rready;

    assign m_arid    = ARID;
    assign m_araddr  = raddr_q;
    assign m_arlen   = count_q;
    assign m_arsize  = 3'd2;
    assign m_arburst = 2'd1;
    assign m_arlock  = 2'd0;
    assign m_arcache = 4'd0;
    assign m_arprot  = 3'd0;
    assign m_arvalid = arvalid_q;

    assign m_awid    = 6'd0;
    assign m_awaddr  = 32'd0;
    assign m_awlen   = 4'd0;
    assign m_awsize  = 3'd0;
    assign m_awburst = 2'd0;
    assign m_awlock  = 2'd0;
    assign m_awcache = 4'd0;
    assign m_awprot  = 3'd0;
    assign m_awvalid = 1'b0;
    assign m_wid     = 6'd0;
    assign m_wdata   = 32'd0;
    assign m_wstrb   = 4'd0;
    assign m_wlast   = 1'b0;
    assign m_wvalid  = 1'b0;
    assign m_bready  = 1'b0;

    assign busy  = busy_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign done  = done_q;
    assign error = error_q;

    assign unused_s = ^{m_rid, m_awready, m_wready, m_bid, m_bresp, m_bvalid};

    // next-state logic for the burst sequencer
    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        count_d   = count_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        error_d   = error_q;
        arvalid_d = arvalid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    raddr_d   = addr;
                    count_d   = burstlen;
                    error_d   = 1'b0;
                    arvalid_d = 1'b1;
                    state_d   = RADDR;
                end else begin
                    arvalid_d = 1'b0;
                end
            end
            RADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RDATA;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            RDATA: begin
                if (beat_s) begin
                    data_d  = m_rdata;
                    valid_d = 1'b1;
                    // rlast must coincide exactly with the final counted beat
                    if (count_q != 4'd0) begin
                        count_d = count_q - 4'd1;
                        error_d = error_q | (m_rresp != 2'd0) | m_rlast;
                    end else begin
                        error_d = error_q | (m_rresp != 2'd0) | ~m_rlast;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            raddr_q   <= 32'd0;
            count_q   <= 4'd0;
            data_q    <= 32'd0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            raddr_q   <= raddr_d;
            count_q   <= count_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            arvalid_q <= arvalid_d;
        end
    end

endmodule

// File: tb/tb_axi_dma_reader.sv
// Directed bench for axi_dma_reader: scripted AXI slave plus a scoreboard
// monitor that checks every valid word against the queued expectation.
module tb_axi_dma_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  m_arid;
    logic [31:0] m_araddr;
    logic [3:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [1:0]  m_arlock;
    logic [3:0]  m_arcache;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [5:0]  m_rid = 6'd0;
    logic [31:0] m_rdata = 32'd0;
    logic [1:0]  m_rresp = 2'd0;
    logic        m_rlast = 1'b0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [5:0]  m_awid;
    logic [31:0] m_awaddr;
    logic [3:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic [1:0]  m_awlock;
    logic [3:0]  m_awcache;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [5:0]  m_wid;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [5:0]  m_bid = 6'd0;
    logic [1:0]  m_bresp = 2'd0;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic        start = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [3:0]  burstlen = 4'd0;
    logic        ready = 1'b0;
    logic        busy;
    logic [31:0] data;
    logic        valid;
    logic        done;
    logic        error;

    int pass_cnt = 0;
    int chk_cnt = 0;
    int valid_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] beat_data[16];
    logic [1:0]  beat_resp[16];
    logic        beat_last[16];

    axi_dma_reader #(.ARID(6'd0)) dut (
        .clk(clk), .reset(reset),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .start(start), .addr(addr), .burstlen(burstlen), .ready(ready),
        .busy(busy), .data(data), .valid(valid), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // scoreboard monitor: every valid word must match the head of the queue
    always @(negedge clk) begin
        if (!reset && valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL valid_unexpected: got data %h with no word expected", data);
            end else begin
                check("data", data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beats(input logic [31:0] base, input int bl);
        for (int i = 0; i < 16; i++) begin
            beat_data[i] = base + i;
            beat_resp[i] = 2'd0;
            beat_last[i] = (i == bl);
        end
    endtask

    task automatic run_xfer(input logic [31:0] a, input logic [3:0] bl, input int ar_dly,
                            input bit tog, input bit exp_err, input bit mid_start);
        bit stable;
        bit rr_ok;
        bit hs;
        int b;
        int cyc;
        int vc0;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i <= int'(bl); i++) exp_q.push_back(beat_data[i]);
        vc0 = valid_cnt;
        tick();
        start = 1'b1; addr = a; burstlen = bl;
        tick();
        start = 1'b0; addr = 32'h1234_5678; burstlen = 4'd9;
        stable = 1'b1;
        for (int c = 0; c <= ar_dly; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("busy_after_start", busy, 1);
                check("error_cleared", error, 0);
            end
            if (!(m_arvalid && m_araddr == a && m_arlen == bl)) stable = 1'b0;
            if (mid_start) begin
                start = (c == 1);
                addr = 32'hFFFF_0000;
                burstlen = 4'hF;
            end
            m_arready = (c == ar_dly);
        end
        tick();
        start = 1'b0;
        m_arready = 1'b0;
        check("ar_stable", stable, 1);
        b = 0; cyc = 0; rr_ok = 1'b1;
        while (b <= int'(bl) && cyc < 200) begin
            m_rvalid = 1'b1;
            m_rdata  = beat_data[b];
            m_rresp  = beat_resp[b];
            m_rlast  = beat_last[b];
            ready    = tog ? pat[cyc % 4] : 1'b1;
            @(negedge clk);
            if (m_rready !== ready || m_arvalid !== 1'b0) rr_ok = 1'b0;
            hs = m_rready;
            tick();
            if (hs) b++;
            cyc++;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'd0;
        check("beats_accepted", b, int'(bl) + 1);
        check("rready_tracks_ready", rr_ok, 1);
        if (!tog) check("throughput_cycles", cyc, int'(bl) + 1);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("valid_with_done", valid, 1);
        check("busy_low", busy, 0);
        check("error_flag", error, exp_err);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("valid_count", valid_cnt - vc0, int'(bl) + 1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_rready", m_rready, 0);
        check("rst_data", data, 0);
        check("rst_araddr", m_araddr, 0);
        check("rst_arlen", m_arlen, 0);
        reset = 1'b0;
        @(negedge clk);
        check("tie_ar_fixed", {m_arburst, m_arsize, m_arcache, m_arlock, m_arid}, {2'd1, 3'd2, 4'd0, 2'd0, 6'd0});
        check("tie_write", {m_awvalid, m_wvalid, m_bready, m_awaddr, m_wdata}, 67'd0);

        // single word
        set_beats(32'hDEAD_BEEF, 0);
        run_xfer(32'h0000_1000, 4'd0, 0, 1'b0, 1'b0, 1'b0);

        // full 16-beat burst with data 0..15
        set_beats(32'h0000_0000, 15);
        run_xfer(32'h0000_2000, 4'd15, 0, 1'b0, 1'b0, 1'b0);

        // AR stall of 5 cycles and ready toggling 1,0,0,1
        set_beats(32'hA000_0000, 3);
        run_xfer(32'h0000_3000, 4'd3, 5, 1'b1, 1'b0, 1'b0);

        // second beat returns SLVERR
        set_beats(32'hB000_0000, 2);
        beat_resp[1] = 2'd2;
        run_xfer(32'h0000_4000, 4'd2, 1, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("error_sticky", error, 1);

        // early rlast on beat 1
        set_beats(32'hC000_0000, 3);
        beat_last[1] = 1'b1;
        run_xfer(32'h0000_5000, 4'd3, 0, 1'b0, 1'b1, 1'b0);

        // missing rlast on the final beat
        set_beats(32'hC100_0000, 3);
        beat_last[3] = 1'b0;
        run_xfer(32'h0000_6000, 4'd3, 2, 1'b0, 1'b1, 1'b0);

        // start while busy during an AR stall is ignored
        set_beats(32'hD000_0000, 2);
        run_xfer(32'h0000_7000, 4'd2, 3, 1'b0, 1'b0, 1'b1);

        // reset in the middle of RDATA after two beats
        set_beats(32'h5500_0000, 7);
        exp_q.push_back(beat_data[0]);
        exp_q.push_back(beat_data[1]);
        tick();
        start = 1'b1; addr = 32'h0000_8000; burstlen = 4'd7;
        tick();
        start = 1'b0;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = beat_data[0]; ready = 1'b1;
        tick();
        m_rdata = beat_data[1];
        tick();
        m_rdata = beat_data[2];
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rready", m_rready, 0);
        check("rst_mid_arvalid", m_arvalid, 0);
        @(negedge clk);
        check("rst_stray_rready", m_rready, 0);
        check("rst_mid_queue", exp_q.size(), 0);
        #1 reset = 1'b0;
        m_rvalid = 1'b0;

        // fresh burst after reset
        set_beats(32'hE000_0000, 1);
        run_xfer(32'h0000_9000, 4'd1, 0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
